// File: rtl/slot_io_arb_pkg.sv
// Shared types and address constants for the slot I/O arbiter.
// Address helpers derive per-slot decode bases from the slot number.
package slot_io_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      WAIT,
      DRIVE,
      HOLD
   } state_t;

   typedef struct packed {
      logic devsel;
      logic iosel;
      logic iostrobe;
   } sel_t;

   localparam logic [15:0] DEVSEL_BASE = 16'hC080;
   localparam logic [15:0] IOSEL_BASE  = 16'hC000;
   localparam logic [15:0] ROM_BASE    = 16'hC800;
   localparam logic [15:0] ROM_RELEASE = 16'hCFFF;

   function automatic logic [15:0] slot_devsel_addr(input logic [2:0] slot);
      return DEVSEL_BASE | {9'h000, slot, 4'h0};
   endfunction

   function automatic logic [15:0] slot_iosel_addr(input logic [2:0] slot);
      return IOSEL_BASE | {5'h00, slot, 8'h00};
   endfunction

endpackage

// File: rtl/prio_onehot_enc.sv
// Lowest-index-wins one-hot priority encoder.
// any_o flags that at least one request bit is set.
module prio_onehot_enc #(
   parameter int N = 4
) (
   input  logic [N-1:0] req_i,
   output logic [N-1:0] grant_o,
   output logic         any_o
);

   localparam logic [N-1:0] ONE = N'(1);

   // two's-complement trick isolates the lowest set bit
   assign grant_o = req_i & (~req_i + ONE);
   assign any_o   = |req_i;

endmodule

// File: rtl/slot_io_arbiter.sv
// Apple II slot bus-cycle sequencer: address decode, $C800 ownership,
// read-requester arbitration and data output-enable timing.
module slot_io_arbiter
   import slot_io_arb_pkg::*;
#(
   parameter int SLOT        = 4,
   parameter int N_REQ       = 4,
   parameter int CLAIM_DELAY = 3,
   parameter int HOLD_CYCLES = 2
) (
   input  logic               clk_logic_i,
   input  logic               system_reset_n_i,
   input  logic               device_reset_n_i,
   input  logic               addr_strobe_i,
   input  logic [15:0]        addr_i,
   input  logic               rw_n_i,
   input  logic               phi0_negedge_i,
   input  logic [N_REQ-1:0]   rd_claim_i,
   input  logic [8*N_REQ-1:0] rd_data_i,
   output logic               devsel_o,
   output logic               iosel_o,
   output logic               iostrobe_o,
   output logic               rom_owner_o,
   output logic [N_REQ-1:0]   grant_o,
   output logic [7:0]         data_o,
   output logic               data_oe_o,
   output logic [7:0]         collision_cnt_o
);

   localparam logic [15:0] DEV_ADDR = slot_devsel_addr(3'(SLOT));
   localparam logic [15:0] IO_ADDR  = slot_iosel_addr(3'(SLOT));
   localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

   state_t state_q, state_d;
   sel_t   sel_q, sel_d;
   logic   owner_q;
   logic   io_hit, rel_hit, rom_hit;

   logic [7:0]       cnt_q, cnt_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [7:0]       data_q, data_d;
   logic             oe_q, oe_d;
   logic [7:0]       coll_q, coll_d;

   logic [N_REQ-1:0] onehot;
   logic             any;
   logic             multi;
   logic [7:0]       pick;

   assign io_hit  = addr_i[15:8] == IO_ADDR[15:8];
   assign rel_hit = addr_i == ROM_RELEASE;
   assign rom_hit = addr_i[15:11] == ROM_BASE[15:11];

   // iostrobe sees ownership as it stood before this strobe's update
   always_comb begin
      sel_d.devsel   = addr_i[15:4] == DEV_ADDR[15:4];
      sel_d.iosel    = io_hit;
      sel_d.iostrobe = rom_hit && owner_q;
   end

   always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
      if (!system_reset_n_i) begin
         sel_q   <= '0;
         owner_q <= 1'b0;
      end else begin
         if (addr_strobe_i) sel_q <= sel_d;
         if (!device_reset_n_i) owner_q <= 1'b0;
         else if (addr_strobe_i && rel_hit) owner_q <= 1'b0;
         else if (addr_strobe_i && io_hit) owner_q <= 1'b1;
      end
   end

   prio_onehot_enc #(
      .N(N_REQ)
   ) u_enc (
      .req_i  (rd_claim_i),
      .grant_o(onehot),
      .any_o  (any)
   );

   assign multi = |(rd_claim_i & (rd_claim_i - ONE));

   always_comb begin
      pick = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (onehot[i]) pick = pick | rd_data_i[8*i +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      data_d  = data_q;
      oe_d    = oe_q;
      coll_d  = coll_q;
      if (addr_strobe_i) begin
         state_d = DECODE;
         grant_d = '0;
         oe_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: ;
            DECODE: begin
               if (rw_n_i && (|sel_q)) begin
                  state_d = WAIT;
                  cnt_d   = 8'(CLAIM_DELAY - 1);
               end else begin
                  state_d = IDLE;
               end
            end
            WAIT: begin
               if (cnt_q == 8'd0) begin
                  if (any) begin
                     state_d = DRIVE;
                     grant_d = onehot;
                     data_d  = pick;
                     oe_d    = 1'b1;
                  end else begin
                     state_d = IDLE;
                     grant_d = '0;
                  end
                  if (multi && coll_q != 8'hFF) coll_d = coll_q + 8'd1;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            DRIVE: begin
               if (phi0_negedge_i) begin
                  state_d = HOLD;
                  cnt_d   = 8'(HOLD_CYCLES - 1);
               end
            end
            HOLD: begin
               if (cnt_q == 8'd0) begin
                  state_d = IDLE;
                  oe_d    = 1'b0;
                  grant_d = '0;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
      if (!system_reset_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         grant_q <= '0;
         data_q  <= '0;
         oe_q    <= 1'b0;
         coll_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         oe_q    <= oe_d;
         coll_q  <= coll_d;
      end
   end

   assign devsel_o        = sel_q.devsel;
   assign iosel_o         = sel_q.iosel;
   assign iostrobe_o      = sel_q.iostrobe;
   assign rom_owner_o     = owner_q;
   assign grant_o         = grant_q;
   assign data_o          = data_q;
   assign data_oe_o       = oe_q;
   assign collision_cnt_o = coll_q;

endmodule

// File: tb/tb_slot_io_arbiter.sv
// Directed bench for slot_io_arbiter (SLOT=4, N_REQ=4).
// Expected values are hand-derived from the bus-cycle timing.
module tb_slot_io_arbiter;

   logic        clk;
   logic        sys_rst_n;
   logic        dev_rst_n;
   logic        addr_strobe;
   logic [15:0] addr;
   logic        rw_n;
   logic        phi0_neg;
   logic [3:0]  claim;
   logic [31:0] rd_data;
   logic        devsel;
   logic        iosel;
   logic        iostrobe;
   logic        owner;
   logic [3:0]  grant;
   logic [7:0]  data;
   logic        oe;
   logic [7:0]  coll;

   int n_chk;
   int n_fail;

   slot_io_arbiter #(
      .SLOT(4),
      .N_REQ(4),
      .CLAIM_DELAY(3),
      .HOLD_CYCLES(2)
   ) dut (
      .clk_logic_i     (clk),
      .system_reset_n_i(sys_rst_n),
      .device_reset_n_i(dev_rst_n),
      .addr_strobe_i   (addr_strobe),
      .addr_i          (addr),
      .rw_n_i          (rw_n),
      .phi0_negedge_i  (phi0_neg),
      .rd_claim_i      (claim),
      .rd_data_i       (rd_data),
      .devsel_o        (devsel),
      .iosel_o         (iosel),
      .iostrobe_o      (iostrobe),
      .rom_owner_o     (owner),
      .grant_o         (grant),
      .data_o          (data),
      .data_oe_o       (oe),
      .collision_cnt_o (coll)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic bus(input logic [15:0] a, input logic rw);
      addr        = a;
      rw_n        = rw;
      addr_strobe = 1'b1;
      tick();
      addr_strobe = 1'b0;
   endtask

   task automatic phi0_end();
      phi0_neg = 1'b1;
      tick();
      phi0_neg = 1'b0;
   endtask

   initial begin
      n_chk       = 0;
      n_fail      = 0;
      sys_rst_n   = 1'b0;
      dev_rst_n   = 1'b1;
      addr_strobe = 1'b0;
      addr        = 16'h0000;
      rw_n        = 1'b1;
      phi0_neg    = 1'b0;
      claim       = 4'b0000;
      rd_data     = {8'h44, 8'h33, 8'h5A, 8'h11};
      tick();
      tick();
      chk("rst_devsel", 32'(devsel), 32'h0);
      chk("rst_oe", 32'(oe), 32'h0);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_coll", 32'(coll), 32'h0);
      sys_rst_n = 1'b1;
      tick();

      // basic devsel read with single claimer
      claim = 4'b0010;
      bus(16'hC0C3, 1'b1);
      chk("rd_devsel", 32'(devsel), 32'h1);
      chk("rd_iosel", 32'(iosel), 32'h0);
      repeat (3) tick();
      chk("rd_grant_early", 32'(grant), 32'h0);
      tick();
      chk("rd_grant", 32'(grant), 32'h2);
      chk("rd_data", 32'(data), 32'h5A);
      chk("rd_oe", 32'(oe), 32'h1);
      claim = 4'b0001;
      tick();
      chk("rd_grant_fixed", 32'(grant), 32'h2);
      phi0_end();
      chk("hold_oe0", 32'(oe), 32'h1);
      tick();
      chk("hold_oe1", 32'(oe), 32'h1);
      tick();
      chk("hold_oe_off", 32'(oe), 32'h0);
      chk("hold_grant_off", 32'(grant), 32'h0);
      chk("hold_data_keep", 32'(data), 32'h5A);

      // expansion ROM ownership sequence, nobody claims
      claim = 4'b0000;
      bus(16'hC400, 1'b1);
      chk("rom_iosel", 32'(iosel), 32'h1);
      chk("rom_own_set", 32'(owner), 32'h1);
      repeat (5) tick();
      chk("noclaim_oe", 32'(oe), 32'h0);
      chk("noclaim_grant", 32'(grant), 32'h0);
      bus(16'hC900, 1'b1);
      chk("rom_strb_c900", 32'(iostrobe), 32'h1);
      repeat (5) tick();
      bus(16'hCFFF, 1'b1);
      chk("rom_strb_cfff", 32'(iostrobe), 32'h1);
      chk("rom_own_clr", 32'(owner), 32'h0);
      repeat (5) tick();
      bus(16'hC900, 1'b1);
      chk("rom_strb_off", 32'(iostrobe), 32'h0);
      repeat (5) tick();

      // collisions, saturating counter
      claim = 4'b1100;
      for (int i = 1; i <= 300; i++) begin
         bus(16'hC0C0, 1'b1);
         repeat (4) tick();
         if (i == 1) begin
            chk("coll_grant", 32'(grant), 32'h4);
            chk("coll_data", 32'(data), 32'h33);
            chk("coll_cnt1", 32'(coll), 32'h1);
         end
         if (i == 254) chk("coll_cnt254", 32'(coll), 32'hFE);
      end
      chk("coll_sat", 32'(coll), 32'hFF);

      // write cycle: decode only, no drive
      claim = 4'b1111;
      bus(16'hC0C5, 1'b0);
      chk("wr_devsel", 32'(devsel), 32'h1);
      repeat (5) tick();
      chk("wr_oe", 32'(oe), 32'h0);
      chk("wr_grant", 32'(grant), 32'h0);
      chk("wr_coll", 32'(coll), 32'hFF);

      // abort during drive
      claim = 4'b0010;
      bus(16'hC0C3, 1'b1);
      repeat (4) tick();
      chk("abort_pre_oe", 32'(oe), 32'h1);
      bus(16'h2000, 1'b1);
      chk("abort_oe", 32'(oe), 32'h0);
      chk("abort_grant", 32'(grant), 32'h0);
      chk("abort_sel", {29'h0, devsel, iosel, iostrobe}, 32'h0);
      repeat (6) tick();
      chk("abort_idle_oe", 32'(oe), 32'h0);

      // async system reset mid-drive with ownership held
      bus(16'hC400, 1'b1);
      repeat (4) tick();
      chk("sr_pre_own", 32'(owner), 32'h1);
      chk("sr_pre_oe", 32'(oe), 32'h1);
      #3;
      sys_rst_n = 1'b0;
      #1;
      chk("sr_own", 32'(owner), 32'h0);
      chk("sr_oe", 32'(oe), 32'h0);
      chk("sr_grant", 32'(grant), 32'h0);
      chk("sr_data", 32'(data), 32'h0);
      chk("sr_coll", 32'(coll), 32'h0);
      chk("sr_sel", {29'h0, devsel, iosel, iostrobe}, 32'h0);
      sys_rst_n = 1'b1;
      tick();

      // device reset clears ownership only
      claim = 4'b0000;
      bus(16'hC400, 1'b1);
      repeat (5) tick();
      claim = 4'b1100;
      bus(16'hC0C0, 1'b1);
      repeat (4) tick();
      chk("dr_pre_own", 32'(owner), 32'h1);
      dev_rst_n = 1'b0;
      tick();
      dev_rst_n = 1'b1;
      chk("dr_own", 32'(owner), 32'h0);
      chk("dr_oe", 32'(oe), 32'h1);
      chk("dr_grant", 32'(grant), 32'h4);
      chk("dr_coll", 32'(coll), 32'h1);
      chk("dr_devsel", 32'(devsel), 32'h1);
      phi0_end();
      repeat (2) tick();
      chk("dr_end_oe", 32'(oe), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
